// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and remap helper for the ROM download router
package rom_dl_pkg;

    localparam int ADDR_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT
    } disp_state_t;

    typedef struct packed {
        logic [ADDR_MAX-1:0] addr;
        logic [7:0]          data;
    } fifo_entry_t;

    typedef struct packed {
        logic [ADDR_MAX-1:0] a;
        logic [1:0]          ds;
    } remap_t;

    // Drop bit 'plane' from the offset to form the word address; that bit picks the lane.
    // plane == 0 degenerates to the linear layout.
    function automatic remap_t remap(input logic [ADDR_MAX-1:0] off, input logic [4:0] plane);
        remap_t              r;
        logic [ADDR_MAX-1:0] low_mask;
        low_mask = ~({ADDR_MAX{1'b1}} << plane);
        r.a  = ((off >> ({1'b0, plane} + 6'd1)) << plane) | (off & low_mask);
        r.ds = {off[plane], ~off[plane]};
        return r;
    endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// rtl/rom_dl_fifo.sv - synchronous FIFO with full/empty/fill status
module rom_dl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_fill
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_fill;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_fill == FULL_LVL);
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/rom_dl_router.sv
// rtl/rom_dl_router.sv - routes ioctl download bytes to windowed toggle-handshake SDRAM write ports
module rom_dl_router #(
    parameter int                  PORTS     = 2,
    parameter int                  AW        = 25,
    parameter int                  SAW       = 23,
    parameter int                  DEPTH     = 4,
    parameter logic [7:0]          INDEX     = 8'd0,
    parameter logic [PORTS*AW-1:0] PORT_BASE = '0,
    parameter logic [PORTS*AW-1:0] PORT_SIZE = '0,
    parameter logic [PORTS*5-1:0]  PLANE_BIT = '0
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [AW-1:0]         ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    output logic [PORTS-1:0]      port_req,
    input  logic [PORTS-1:0]      port_ack,
    output logic [PORTS*SAW-1:0]  port_a,
    output logic [PORTS*2-1:0]    port_ds,
    output logic [PORTS*16-1:0]   port_d,
    output logic [PORTS-1:0]      port_we,
    output logic                  dl_done,
    output logic                  dl_drop,
    output logic [15:0]           dl_miss
);
    import rom_dl_pkg::*;

    localparam int FW = $clog2(DEPTH);
    localparam logic [FW:0] WAIT_LVL = (FW+1)'(DEPTH - 1);

    disp_state_t          r_state;
    disp_state_t          w_next;
    fifo_entry_t          w_din;
    fifo_entry_t          w_head;
    logic                 w_accept;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_miss;
    logic [FW:0]          w_fill;
    logic [AW-1:0]        w_head_addr;
    logic [AW-1:0]        w_off [PORTS];
    remap_t               w_map [PORTS];
    logic [PORTS-1:0]     w_hit;
    logic [PORTS-1:0]     w_acked;
    logic [PORTS*SAW-1:0] w_a;
    logic [PORTS*2-1:0]   w_ds;
    logic [PORTS-1:0]     r_hit;
    logic [PORTS-1:0]     r_we;
    // Toggle state must survive reset so the SDRAM side never sees a phantom request.
    logic [PORTS-1:0]     r_req = '0;
    logic [PORTS*SAW-1:0] r_a;
    logic [PORTS*2-1:0]   r_ds;
    logic [PORTS*16-1:0]  r_d;
    logic [15:0]          r_miss;
    logic                 r_wait;
    logic                 r_drop;
    logic                 r_done;
    logic                 r_pend;
    logic                 r_dl_prev;

    assign w_accept = ioctl_download & (ioctl_index == INDEX) & ioctl_wr;
    assign w_din    = '{addr: ADDR_MAX'(ioctl_addr), data: ioctl_dout};
    assign w_acked  = ~(port_ack ^ r_req);

    rom_dl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (w_fill)
    );

    always_comb begin
        w_head_addr = AW'(w_head.addr);
        for (int i = 0; i < PORTS; i++) begin
            w_off[i]            = w_head_addr - PORT_BASE[i*AW +: AW];
            w_hit[i]            = w_off[i] < PORT_SIZE[i*AW +: AW];
            w_map[i]            = remap(ADDR_MAX'(w_off[i]), PLANE_BIT[i*5 +: 5]);
            w_a[i*SAW +: SAW]   = SAW'(w_map[i].a);
            w_ds[i*2 +: 2]      = w_map[i].ds;
        end
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_miss = 1'b0;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next = S_DECODE;
            S_DECODE: begin
                if (w_hit == '0) begin
                    w_pop  = 1'b1;
                    w_miss = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                // The entry retires only when the slowest hit port has answered.
                if ((r_we & ~w_acked) == '0) begin
                    w_pop  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_hit     <= '0;
            r_we      <= '0;
            r_a       <= '0;
            r_ds      <= '0;
            r_d       <= '0;
            r_miss    <= '0;
            r_wait    <= 1'b0;
            r_drop    <= 1'b0;
            r_done    <= 1'b0;
            r_pend    <= 1'b0;
            r_dl_prev <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dl_prev <= ioctl_download;
            r_wait    <= (w_fill >= WAIT_LVL);
            if (r_state == S_DECODE) r_hit <= w_hit;
            if (w_miss && r_miss != 16'hFFFF) r_miss <= r_miss + 16'd1;
            if (ioctl_download & ~r_dl_prev) r_drop <= 1'b0;
            if (w_accept & w_full) r_drop <= 1'b1;
            for (int i = 0; i < PORTS; i++) begin
                if (r_state == S_ISSUE && r_hit[i]) begin
                    r_a[i*SAW +: SAW] <= w_a[i*SAW +: SAW];
                    r_ds[i*2 +: 2]    <= w_ds[i*2 +: 2];
                    r_d[i*16 +: 16]   <= {2{w_head.data}};
                    r_we[i]           <= 1'b1;
                end else if (r_state == S_WAIT && w_acked[i]) begin
                    r_we[i] <= 1'b0;
                end
            end
            r_done <= 1'b0;
            if (~ioctl_download & r_dl_prev) begin
                r_pend <= 1'b1;
            end else if (r_pend && w_empty && r_state == S_IDLE) begin
                r_done <= 1'b1;
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < PORTS; i++) begin
            if (!reset && r_state == S_ISSUE && r_hit[i]) r_req[i] <= ~r_req[i];
        end
    end

    assign ioctl_wait = r_wait;
    assign port_req   = r_req;
    assign port_a     = r_a;
    assign port_ds    = r_ds;
    assign port_d     = r_d;
    assign port_we    = r_we;
    assign dl_done    = r_done;
    assign dl_drop    = r_drop;
    assign dl_miss    = r_miss;

endmodule

// File: tb/tb_rom_dl_router.sv
// tb/tb_rom_dl_router.sv - scoreboard bench for rom_dl_router (linear, plane, overlap, overflow, done)
module tb_rom_dl_router;
    localparam int AW = 25, SAW = 23, PORTS = 2, DEPTH = 4;
    localparam logic [PORTS*AW-1:0] BASE_A  = {25'h10000, 25'h00000};
    localparam logic [PORTS*AW-1:0] SIZE_A  = {25'h0C000, 25'h10000};
    localparam logic [PORTS*5-1:0]  PLANE_A = {5'd14, 5'd0};
    localparam logic [PORTS*AW-1:0] BASE_B  = {25'h08000, 25'h00000};
    localparam logic [PORTS*AW-1:0] SIZE_B  = {25'h10000, 25'h10000};
    localparam logic [PORTS*5-1:0]  PLANE_B = {5'd0, 5'd0};

    typedef struct packed {
        logic [1:0]     dut;
        logic [1:0]     port;
        logic [SAW-1:0] a;
        logic [1:0]     ds;
        logic [15:0]    d;
    } rec_t;

    logic clk = 1'b0, reset = 1'b1, dl = 1'b0, wr = 1'b0;
    logic [7:0] idx = 8'd0, dout = 8'd0;
    logic [AW-1:0] addr = '0;

    logic wait_a, done_a, drop_a, wait_b, done_b, drop_b;
    logic [15:0] miss_a, miss_b;
    logic [1:0] req_a, we_a, req_b, we_b;
    logic [1:0] ack_a = 2'b00, ack_b = 2'b00;
    logic [2*SAW-1:0] pa_a, pa_b;
    logic [3:0] ds_a, ds_b;
    logic [31:0] d_a, d_b;

    bit [1:0] hold_a = 2'b00, hold_b = 2'b00;
    int dly_a [2] = '{0, 0};
    int dly_b [2] = '{0, 0};
    int cnt_a [2] = '{0, 0};
    int cnt_b [2] = '{0, 0};

    rec_t exp_q [$];
    rec_t obs_q [$];
    int   obs_cyc [$];
    int   cyc = 0, done_cnt = 0, done_cyc = 0, rd = 0;
    int   n_total = 0, n_pass = 0, n_fail = 0;
    logic [1:0] prev_a = 2'b00, prev_b = 2'b00;

    always #5 clk = ~clk;

    rom_dl_router #(.PORTS(PORTS), .AW(AW), .SAW(SAW), .DEPTH(DEPTH), .INDEX(8'd0),
                    .PORT_BASE(BASE_A), .PORT_SIZE(SIZE_A), .PLANE_BIT(PLANE_A)) u_a (
        .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait_a), .port_req(req_a), .port_ack(ack_a),
        .port_a(pa_a), .port_ds(ds_a), .port_d(d_a), .port_we(we_a), .dl_done(done_a),
        .dl_drop(drop_a), .dl_miss(miss_a));

    rom_dl_router #(.PORTS(PORTS), .AW(AW), .SAW(SAW), .DEPTH(DEPTH), .INDEX(8'd1),
                    .PORT_BASE(BASE_B), .PORT_SIZE(SIZE_B), .PLANE_BIT(PLANE_B)) u_b (
        .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait_b), .port_req(req_b), .port_ack(ack_b),
        .port_a(pa_b), .port_ds(ds_b), .port_d(d_b), .port_we(we_b), .dl_done(done_b),
        .dl_drop(drop_b), .dl_miss(miss_b));

    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM-side responders: echo req onto ack after a programmable delay unless held.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ack_a[i] != req_a[i] && !hold_a[i]) begin
                if (cnt_a[i] >= dly_a[i]) begin ack_a[i] <= req_a[i]; cnt_a[i] <= 0; end
                else cnt_a[i] <= cnt_a[i] + 1;
            end else cnt_a[i] <= 0;
            if (ack_b[i] != req_b[i] && !hold_b[i]) begin
                if (cnt_b[i] >= dly_b[i]) begin ack_b[i] <= req_b[i]; cnt_b[i] <= 0; end
                else cnt_b[i] <= cnt_b[i] + 1;
            end else cnt_b[i] <= 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (req_a[i] !== prev_a[i]) begin
                obs_q.push_back('{dut: 2'd0, port: 2'(i), a: pa_a[i*SAW +: SAW], ds: ds_a[i*2 +: 2], d: d_a[i*16 +: 16]});
                obs_cyc.push_back(cyc);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (req_b[i] !== prev_b[i]) begin
                obs_q.push_back('{dut: 2'd1, port: 2'(i), a: pa_b[i*SAW +: SAW], ds: ds_b[i*2 +: 2], d: d_b[i*16 +: 16]});
                obs_cyc.push_back(cyc);
            end
        end
        prev_a <= req_a;
        prev_b <= req_b;
        if (done_a === 1'b1) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    end

    // Reference model: the plane bit is removed from the offset to form the word address.
    task automatic push_exp(input logic [7:0] ix, input logic [AW-1:0] ad, input logic [7:0] dt);
        logic [AW-1:0] base, size, off;
        logic [4:0] pb;
        logic [SAW-1:0] a;
        int j;
        for (int p = 0; p < 2; p++) begin
            base = (ix == 8'd0) ? BASE_A[p*AW +: AW] : BASE_B[p*AW +: AW];
            size = (ix == 8'd0) ? SIZE_A[p*AW +: AW] : SIZE_B[p*AW +: AW];
            pb   = (ix == 8'd0) ? PLANE_A[p*5 +: 5] : PLANE_B[p*5 +: 5];
            off  = ad - base;
            if (off < size) begin
                a = '0;
                j = 0;
                for (int b = 0; b < SAW + 2; b++) begin
                    if (b != int'(pb)) begin
                        if (j < SAW) a[j] = off[b];
                        j++;
                    end
                end
                exp_q.push_back('{dut: ix[1:0], port: 2'(p), a: a, ds: {off[pb], ~off[pb]}, d: {dt, dt}});
            end
        end
    endtask

    task automatic send(input logic [7:0] ix, input logic [AW-1:0] ad, input logic [7:0] dt, input bit expect_it);
        @(negedge clk);
        idx = ix; addr = ad; dout = dt; wr = 1'b1;
        if (expect_it) push_exp(ix, ad, dt);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        wr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic settle(output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        repeat (20) @(negedge clk);
        while (obs_q.size() < exp_q.size() || we_a != 2'b00 || we_b != 2'b00) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin ok = 1'b0; break; end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_total++;
        if (req_a !== 2'b00 || req_b !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b/%b, expected 00/00", req_a, req_b); end else n_pass++;
        n_total++;
        if ({wait_a, we_a, done_a, drop_a, wait_b, we_b, done_b, drop_b} !== 10'd0) begin n_fail++; $display("FAIL reset_flags: got %b, expected 0", {wait_a, we_a, done_a, drop_a, wait_b, we_b, done_b, drop_b}); end else n_pass++;
        n_total++;
        if (miss_a !== 16'd0 || miss_b !== 16'd0) begin n_fail++; $display("FAIL reset_miss: got %h/%h, expected 0", miss_a, miss_b); end else n_pass++;
        n_total++;
        if ({pa_a, ds_a, d_a, pa_b, ds_b, d_b} !== '0) begin n_fail++; $display("FAIL reset_port_outputs: got nonzero, expected 0"); end else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        dl = 1'b1;
    endtask

    task automatic test_linear;
        bit ok;
        send(8'd0, 25'h00003, 8'hA5, 1'b1);
        gap(2);
        settle(ok);
        n_total++;
        if (!ok) begin n_fail++; $display("FAIL linear_timeout: got %0d toggles, expected %0d", obs_q.size(), exp_q.size()); end else n_pass++;
        n_total++;
        if (obs_q.size() < 1 || obs_q[obs_q.size()-1] !== rec_t'({2'd0, 2'd0, 23'd1, 2'b10, 16'hA5A5}))
            begin n_fail++; $display("FAIL linear_a5: got %h, expected %h", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : rec_t'(0), rec_t'({2'd0, 2'd0, 23'd1, 2'b10, 16'hA5A5})); end
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            send(8'd0, 25'($urandom_range(0, 32'h1BFFF)), 8'($urandom), 1'b1);
            gap(5 + $urandom_range(0, 3));
        end
        settle(ok);
        n_total++;
        if (!ok) begin n_fail++; $display("FAIL random_timeout: got %0d toggles, expected %0d", obs_q.size(), exp_q.size()); end else n_pass++;
        while (rd < obs_q.size() && rd < exp_q.size()) begin
            n_total++;
            if (obs_q[rd] !== exp_q[rd]) begin n_fail++; $display("FAIL sb_linear[%0d]: got %h, expected %h", rd, obs_q[rd], exp_q[rd]); end else n_pass++;
            rd++;
        end
        n_total++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL linear_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end else n_pass++;
    endtask

    task automatic test_plane;
        bit ok;
        send(8'd0, 25'h14001, 8'h5A, 1'b1);
        gap(2);
        settle(ok);
        n_total++;
        if (!ok || obs_q.size() != exp_q.size() || obs_q.size() < 1) begin n_fail++; $display("FAIL plane_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        else begin
            if (obs_q[obs_q.size()-1] !== rec_t'({2'd0, 2'd1, 23'd1, 2'b10, 16'h5A5A})) begin n_fail++; $display("FAIL plane_14001: got %h, expected %h", obs_q[obs_q.size()-1], rec_t'({2'd0, 2'd1, 23'd1, 2'b10, 16'h5A5A})); end
            else n_pass++;
        end
        while (rd < obs_q.size() && rd < exp_q.size()) begin
            n_total++;
            if (obs_q[rd] !== exp_q[rd]) begin n_fail++; $display("FAIL sb_plane[%0d]: got %h, expected %h", rd, obs_q[rd], exp_q[rd]); end else n_pass++;
            rd++;
        end
    endtask

    task automatic test_overlap;
        bit ok;
        int r0, n;
        r0 = obs_q.size();
        dly_b[1] = 10;
        send(8'd1, 25'h09001, 8'h3C, 1'b1);
        send(8'd1, 25'h00002, 8'h77, 1'b1);
        @(negedge clk);
        wr = 1'b0;
        n = 0;
        while (obs_q.size() < r0 + 2 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        n_total++;
        if (we_b !== 2'b10) begin n_fail++; $display("FAIL overlap_we: got %b, expected 10", we_b); end else n_pass++;
        settle(ok);
        dly_b[1] = 0;
        n_total++;
        if (!ok || obs_q.size() < r0 + 3) begin n_fail++; $display("FAIL overlap_count: got %0d, expected %0d", obs_q.size(), r0 + 3); end
        else begin
            n_pass++;
            n_total++;
            if (obs_cyc[r0] != obs_cyc[r0+1]) begin n_fail++; $display("FAIL overlap_same_cycle: got %0d vs %0d, expected equal", obs_cyc[r0], obs_cyc[r0+1]); end else n_pass++;
            n_total++;
            if (obs_cyc[r0+2] - obs_cyc[r0] < 12) begin n_fail++; $display("FAIL overlap_pop_after_slow_ack: got gap %0d, expected >= 12", obs_cyc[r0+2] - obs_cyc[r0]); end else n_pass++;
        end
        while (rd < obs_q.size() && rd < exp_q.size()) begin
            n_total++;
            if (obs_q[rd] !== exp_q[rd]) begin n_fail++; $display("FAIL sb_overlap[%0d]: got %h, expected %h", rd, obs_q[rd], exp_q[rd]); end else n_pass++;
            rd++;
        end
    endtask

    task automatic test_miss;
        bit ok;
        send(8'd0, 25'h1F000, 8'h11, 1'b0);
        gap(2);
        settle(ok);
        n_total++;
        if (miss_a !== 16'd1 || miss_b !== 16'd0) begin n_fail++; $display("FAIL miss_count: got %0d/%0d, expected 1/0", miss_a, miss_b); end else n_pass++;
        n_total++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL miss_no_req: got %0d toggles, expected %0d", obs_q.size(), exp_q.size()); end else n_pass++;
    endtask

    task automatic test_overflow;
        bit ok;
        logic [1:0] snap;
        hold_a = 2'b11;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                n_total++;
                if (wait_a !== 1'b0) begin n_fail++; $display("FAIL wait_early: got %b, expected 0", wait_a); end else n_pass++;
            end
            send(8'd0, 25'(32'h40 + k), 8'(8'hC0 + k), k < 4);
        end
        @(negedge clk);
        wr = 1'b0;
        n_total++;
        if (wait_a !== 1'b1) begin n_fail++; $display("FAIL wait_full: got %b, expected 1", wait_a); end else n_pass++;
        n_total++;
        if (drop_a !== 1'b1) begin n_fail++; $display("FAIL drop_set: got %b, expected 1", drop_a); end else n_pass++;
        repeat (3) @(negedge clk);
        snap = req_a;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (req_a !== snap || we_a !== 2'b00 || drop_a !== 1'b0 || wait_a !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset: got req=%b we=%b drop=%b wait=%b, expected req=%b we=00 drop=0 wait=0", req_a, we_a, drop_a, wait_a, snap); end
        else n_pass++;
        reset = 1'b0;
        repeat (3) exp_q.pop_back();
        hold_a = 2'b00;
        settle(ok);
        n_total++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL overflow_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end else n_pass++;
        while (rd < obs_q.size() && rd < exp_q.size()) begin
            n_total++;
            if (obs_q[rd] !== exp_q[rd]) begin n_fail++; $display("FAIL sb_overflow[%0d]: got %h, expected %h", rd, obs_q[rd], exp_q[rd]); end else n_pass++;
            rd++;
        end
    endtask

    task automatic test_done;
        bit ok;
        int d0;
        d0 = done_cnt;
        send(8'd0, 25'h00020, 8'h21, 1'b1);
        send(8'd0, 25'h00021, 8'h22, 1'b1);
        send(8'd0, 25'h00022, 8'h23, 1'b1);
        @(negedge clk);
        wr = 1'b0;
        dl = 1'b0;
        settle(ok);
        n_total++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL done_count_reqs: got %0d, expected %0d", obs_q.size(), exp_q.size()); end else n_pass++;
        n_total++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL done_pulses: got %0d, expected 1", done_cnt - d0); end else n_pass++;
        n_total++;
        if (obs_cyc.size() < 1 || done_cyc - obs_cyc[obs_cyc.size()-1] != 3)
            begin n_fail++; $display("FAIL done_timing: got %0d cycles after last req, expected 3", (obs_cyc.size() > 0) ? done_cyc - obs_cyc[obs_cyc.size()-1] : -1); end
        else n_pass++;
        while (rd < obs_q.size() && rd < exp_q.size()) begin
            n_total++;
            if (obs_q[rd] !== exp_q[rd]) begin n_fail++; $display("FAIL sb_done[%0d]: got %h, expected %h", rd, obs_q[rd], exp_q[rd]); end else n_pass++;
            rd++;
        end
    endtask

    initial begin
        test_reset;
        test_linear;
        test_plane;
        test_overlap;
        test_miss;
        test_overflow;
        test_done;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
